// File: rtl/hsl_arbiter_if.sv
// hsl_arbiter_if
// ----------------------------------------------------------------------------
// Bundles every non-clock, non-reset signal of hsl_arbiter.
//
//   slave  modport : seen by the arbiter itself
//   master modport : seen by whatever drives the requesters and the converter
//
// Signal summary (slave view)
//   req0, req1            in   requester N presents a pixel
//   rgb0, rgb1      [23:0] in  pixel {R, G, B}, 8 bits per channel
//   gnt0, gnt1            out  combinational grant, transfer when reqN & gntN
//   conv_red/green/blue [7:0] out  registered drive to the shared converter
//   conv_hue/sat/light  [9:0] in   converter results
//   o_valid, o_id         out  result strobe and owning requester
//   o_hue/o_sat/o_light [9:0] out  registered result, held while o_valid low
//   flush                 in   stop granting and drain
//   flush_done            out  pipeline empty after flush
//   busy                  out  pixels in flight or not in RUN
//   cnt0, cnt1     [15:0] out  per-requester transfer counts
//                               (only when HSL_ARB_STATS_EN is defined)
// ----------------------------------------------------------------------------
interface hsl_arbiter_if;

    logic        req0;
    logic        req1;
    logic [23:0] rgb0;
    logic [23:0] rgb1;
    logic        gnt0;
    logic        gnt1;

    logic [7:0]  conv_red;
    logic [7:0]  conv_green;
    logic [7:0]  conv_blue;
    logic [9:0]  conv_hue;
    logic [9:0]  conv_sat;
    logic [9:0]  conv_light;

    logic        o_valid;
    logic        o_id;
    logic [9:0]  o_hue;
    logic [9:0]  o_sat;
    logic [9:0]  o_light;

    logic        flush;
    logic        flush_done;
    logic        busy;

`ifdef HSL_ARB_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    modport slave (
        input  req0, req1, rgb0, rgb1,
        input  conv_hue, conv_sat, conv_light,
        input  flush,
        output gnt0, gnt1,
        output conv_red, conv_green, conv_blue,
        output o_valid, o_id, o_hue, o_sat, o_light,
        output flush_done, busy
`ifdef HSL_ARB_STATS_EN
        ,
        output cnt0, cnt1
`endif
    );

    modport master (
        output req0, req1, rgb0, rgb1,
        output conv_hue, conv_sat, conv_light,
        output flush,
        input  gnt0, gnt1,
        input  conv_red, conv_green, conv_blue,
        input  o_valid, o_id, o_hue, o_sat, o_light,
        input  flush_done, busy
`ifdef HSL_ARB_STATS_EN
        ,
        input  cnt0, cnt1
`endif
    );

endinterface

// File: rtl/hsl_arbiter.sv
// hsl_arbiter
// ----------------------------------------------------------------------------
// Two-requester round-robin arbiter in front of a shared RGB-to-HSL converter.
//
// A granted pixel is registered into conv_red/green/blue on its transfer edge
// E. A tag (valid + requester id) follows it through a CONV_LAT-deep shift
// register; at edge E+CONV_LAT the converter result is sampled together with
// the tag, and at edge E+CONV_LAT+1 it appears on o_valid/o_id/o_hue/o_sat/
// o_light. A flush request stops granting, drains everything already accepted
// and then raises flush_done until flush is released.
//
// Parameters
//   CONV_LAT   converter latency in clock edges, 1..4
//
// Ports
//   clk        clock, everything on posedge
//   reset      asynchronous active-high reset
//   bus        hsl_arbiter_if.slave, see the interface file for the signals
//
// Optional feature
//   HSL_ARB_STATS_EN  when defined, adds 16-bit wrapping per-requester transfer
//                     counters bus.cnt0 / bus.cnt1.
// ----------------------------------------------------------------------------
module hsl_arbiter #(
    parameter int unsigned CONV_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    hsl_arbiter_if.slave     bus
);

    if (CONV_LAT < 1 || CONV_LAT > 4) begin : g_bad_conv_lat
        $error("hsl_arbiter: CONV_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Grant and transfer
    logic        gnt0, gnt1;
    logic        xfer;
    logic [23:0] pix;
    logic        ptr_q, ptr_d;

    // Converter drive
    logic [7:0]  conv_red_q, conv_green_q, conv_blue_q;

    // Tag pipeline running alongside the converter
    logic [CONV_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [CONV_LAT-1:0] tag_id_q, tag_id_d;

    // Sample stage: converter result captured when the tag leaves the pipe
    logic        smp_vld_q;
    logic        smp_id_q;
    logic [9:0]  smp_hue_q, smp_sat_q, smp_light_q;

    // Output stage
    logic        o_valid_q;
    logic        o_id_q;
    logic [9:0]  o_hue_q, o_sat_q, o_light_q;

    logic        pipe_empty;
    logic        flush_done;
    logic        busy;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    assign pipe_empty = ~(|tag_vld_q) & ~smp_vld_q & ~o_valid_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (bus.flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pipe_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!bus.flush) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (grant, flush_done, busy)
    // ------------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Reset term keeps grants low even though state_q already reads RUN.
        if (!reset && state_q == StRun && !bus.flush) begin
            if (bus.req0 && bus.req1) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = bus.req0;
                gnt1 = bus.req1;
            end
        end
        flush_done = (state_q == StDone);
        busy       = (|tag_vld_q) | smp_vld_q | (state_q != StRun);
    end

    // A grant is only ever raised alongside its request, so any grant is a
    // transfer and gnt1 doubles as the id of the transferring requester.
    assign xfer = gnt0 | gnt1;
    assign pix  = gnt1 ? bus.rgb1 : bus.rgb0;

    // Pointer names the requester favoured on the next contention and always
    // moves to the one that did not just transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = gnt0;
        end
    end

    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = xfer;
        tag_id_d[0]  = gnt1;
        for (int unsigned i = 1; i < CONV_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= 1'b0;
            conv_red_q   <= 8'd0;
            conv_green_q <= 8'd0;
            conv_blue_q  <= 8'd0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            if (xfer) begin
                conv_red_q   <= pix[23:16];
                conv_green_q <= pix[15:8];
                conv_blue_q  <= pix[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_vld_q   <= 1'b0;
            smp_id_q    <= 1'b0;
            smp_hue_q   <= 10'd0;
            smp_sat_q   <= 10'd0;
            smp_light_q <= 10'd0;
        end else begin
            smp_vld_q <= tag_vld_q[CONV_LAT-1];
            if (tag_vld_q[CONV_LAT-1]) begin
                smp_id_q    <= tag_id_q[CONV_LAT-1];
                smp_hue_q   <= bus.conv_hue;
                smp_sat_q   <= bus.conv_sat;
                smp_light_q <= bus.conv_light;
            end
        end
    end

    // Result registers only load on a valid sample so they hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid_q <= 1'b0;
            o_id_q    <= 1'b0;
            o_hue_q   <= 10'd0;
            o_sat_q   <= 10'd0;
            o_light_q <= 10'd0;
        end else begin
            o_valid_q <= smp_vld_q;
            if (smp_vld_q) begin
                o_id_q    <= smp_id_q;
                o_hue_q   <= smp_hue_q;
                o_sat_q   <= smp_sat_q;
                o_light_q <= smp_light_q;
            end
        end
    end

`ifdef HSL_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Per-requester transfer counters, wrapping at 16 bits
    // ------------------------------------------------------------------------
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (gnt0) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (gnt1) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;
`endif

    // ------------------------------------------------------------------------
    // Interface drive
    // ------------------------------------------------------------------------
    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.conv_red   = conv_red_q;
    assign bus.conv_green = conv_green_q;
    assign bus.conv_blue  = conv_blue_q;
    assign bus.o_valid    = o_valid_q;
    assign bus.o_id       = o_id_q;
    assign bus.o_hue      = o_hue_q;
    assign bus.o_sat      = o_sat_q;
    assign bus.o_light    = o_light_q;
    assign bus.flush_done = flush_done;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_hsl_arbiter.sv
// tb_hsl_arbiter
// ----------------------------------------------------------------------------
// Directed bench for hsl_arbiter. Instance u_dut1 uses CONV_LAT=1, instance
// u_dut4 uses CONV_LAT=4. The converter is modelled as a fixed bit mapping
// (hue = {2'b11,R}, sat = {2'b10,G}, light = {2'b01,B}) whose output trails
// conv_* by CONV_LAT-1 register stages.
// ----------------------------------------------------------------------------
module tb_hsl_arbiter;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    hsl_arbiter_if a ();
    hsl_arbiter_if b ();

    hsl_arbiter #(.CONV_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(a));
    hsl_arbiter #(.CONV_LAT(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b));

    // Converter model for the CONV_LAT=1 instance: no extra stages.
    assign a.conv_hue   = {2'b11, a.conv_red};
    assign a.conv_sat   = {2'b10, a.conv_green};
    assign a.conv_light = {2'b01, a.conv_blue};

    // Converter model for the CONV_LAT=4 instance: three extra stages.
    logic [23:0] d1, d2, d3;
    always_ff @(posedge clk) begin
        d1 <= {b.conv_red, b.conv_green, b.conv_blue};
        d2 <= d1;
        d3 <= d2;
    end
    assign b.conv_hue   = {2'b11, d3[23:16]};
    assign b.conv_sat   = {2'b10, d3[15:8]};
    assign b.conv_light = {2'b01, d3[7:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] exp_hue(input logic [23:0] rgb);
        return {2'b11, rgb[23:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int nvalid;
    int ndrain;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        a.req0 = 1'b0; a.req1 = 1'b0; a.rgb0 = 24'd0; a.rgb1 = 24'd0; a.flush = 1'b0;
        b.req0 = 1'b0; b.req1 = 1'b0; b.rgb0 = 24'd0; b.rgb1 = 24'd0; b.flush = 1'b0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        a.req0 = 1'b1;
        #1;
        chk("rst_gnt0", 32'(a.gnt0), 32'd0);
        chk("rst_o_valid", 32'(a.o_valid), 32'd0);
        chk("rst_o_hue", 32'(a.o_hue), 32'd0);
        chk("rst_conv_red", 32'(a.conv_red), 32'd0);
        chk("rst_flush_done", 32'(a.flush_done), 32'd0);
        chk("rst_busy", 32'(a.busy), 32'd0);
        a.req0 = 1'b0;
        reset  = 1'b0;
        #1;

        // ---------------- Lone requester ----------------
        a.req0 = 1'b1;
        a.rgb0 = 24'hFF0000;
        #1;
        chk("lone_gnt0", 32'(a.gnt0), 32'd1);
        chk("lone_gnt1", 32'(a.gnt1), 32'd0);
        tick();                                   // edge E
        a.req0 = 1'b0;
        chk("lone_conv_red", 32'(a.conv_red), 32'hFF);
        chk("lone_conv_green", 32'(a.conv_green), 32'h00);
        chk("lone_busy", 32'(a.busy), 32'd1);
        chk("lone_ov_e0", 32'(a.o_valid), 32'd0);
        tick();                                   // E+1
        chk("lone_ov_e1", 32'(a.o_valid), 32'd0);
        tick();                                   // E+2
        chk("lone_ov_e2", 32'(a.o_valid), 32'd1);
        chk("lone_o_id", 32'(a.o_id), 32'd0);
        chk("lone_o_hue", 32'(a.o_hue), 32'h3FF);
        chk("lone_o_sat", 32'(a.o_sat), 32'h200);
        chk("lone_o_light", 32'(a.o_light), 32'h100);
        tick();
        chk("lone_ov_after", 32'(a.o_valid), 32'd0);
        chk("lone_hold_hue", 32'(a.o_hue), 32'h3FF);
        chk("lone_busy_idle", 32'(a.busy), 32'd0);

        // ---------------- Contention ----------------
        do_reset();
        a.rgb0 = 24'h102030;
        a.rgb1 = 24'hA0B0C0;
        for (int i = 0; i < 8; i++) begin
            a.req0 = (i < 6);
            a.req1 = (i < 6);
            #1;
            if (i < 6) begin
                chk($sformatf("cont_gnt0_%0d", i), 32'(a.gnt0), 32'(i % 2 == 0));
                chk($sformatf("cont_gnt1_%0d", i), 32'(a.gnt1), 32'(i % 2 == 1));
            end
            tick();
            if (i >= 2) begin
                chk($sformatf("cont_ov_%0d", i), 32'(a.o_valid), 32'd1);
                chk($sformatf("cont_id_%0d", i), 32'(a.o_id), 32'((i - 2) % 2));
                chk($sformatf("cont_hue_%0d", i), 32'(a.o_hue),
                    32'(((i - 2) % 2 == 0) ? exp_hue(a.rgb0) : exp_hue(a.rgb1)));
            end
        end
        tick();
        chk("cont_ov_end", 32'(a.o_valid), 32'd0);
        chk("cont_hold_hue", 32'(a.o_hue), 32'h3A0);
`ifdef HSL_ARB_STATS_EN
        chk("cont_cnt0", 32'(a.cnt0), 32'd3);
        chk("cont_cnt1", 32'(a.cnt1), 32'd3);
`endif

        // ---------------- Flush ----------------
        do_reset();
        nvalid = 0;
        a.req0 = 1'b1;
        a.req1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a.rgb0 = 24'h010203 + 24'(c);
            #1;
            chk($sformatf("flush_gnt_%0d", c), 32'(a.gnt0), 32'd1);
            tick();
            if (a.o_valid) nvalid++;
        end
        a.flush = 1'b1;
        #1;
        chk("flush_gnt_c3", 32'(a.gnt0), 32'd0);
        tick();                                   // edge F: RUN -> DRAIN
        if (a.o_valid) nvalid++;
        ndrain = 0;
        while (!a.flush_done && ndrain < 8) begin
            chk("drain_gnt0", 32'(a.gnt0), 32'd0);
            tick();
            ndrain++;
            if (a.o_valid) nvalid++;
        end
        chk("flush_drain_len", 32'(ndrain), 32'd3);
        chk("flush_nvalid", 32'(nvalid), 32'd3);
        chk("flush_done", 32'(a.flush_done), 32'd1);
        chk("flush_busy", 32'(a.busy), 32'd1);
        tick();
        chk("flush_done_hold", 32'(a.flush_done), 32'd1);
        a.flush = 1'b0;
        #1;
        chk("done_gnt0", 32'(a.gnt0), 32'd0);
        tick();                                   // DONE -> RUN
        chk("resume_flush_done", 32'(a.flush_done), 32'd0);
        chk("resume_gnt0", 32'(a.gnt0), 32'd1);

        // ---------------- Reset mid-stream ----------------
        tick();                                   // transfer 1
        tick();                                   // transfer 2
        chk("mid_busy_inflight", 32'(a.busy), 32'd1);
        chk("mid_ov_before", 32'(a.o_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt0", 32'(a.gnt0), 32'd0);
        chk("mid_rst_busy", 32'(a.busy), 32'd0);
        a.req0 = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mid_ov_%0d", k), 32'(a.o_valid), 32'd0);
        end
        chk("mid_busy", 32'(a.busy), 32'd0);
        a.req0 = 1'b1;
        a.req1 = 1'b1;
        #1;
        chk("mid_ptr_gnt0", 32'(a.gnt0), 32'd1);
        chk("mid_ptr_gnt1", 32'(a.gnt1), 32'd0);
        a.req0 = 1'b0;
        a.req1 = 1'b0;
        tick();

        // ---------------- CONV_LAT = 4 ----------------
        b.req1 = 1'b1;
        b.rgb1 = 24'h123456;
        #1;
        chk("lat4_gnt1", 32'(b.gnt1), 32'd1);
        tick();                                   // edge E
        b.req1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("lat4_ov_e%0d", k), 32'(b.o_valid), 32'(k == 5));
        end
        chk("lat4_o_id", 32'(b.o_id), 32'd1);
        chk("lat4_o_hue", 32'(b.o_hue), 32'h312);
        chk("lat4_o_sat", 32'(b.o_sat), 32'h234);
        chk("lat4_o_light", 32'(b.o_light), 32'h156);

`ifdef HSL_ARB_STATS_EN
        // ---------------- Statistics wrap ----------------
        do_reset();
        a.req1 = 1'b1;
        for (int k = 0; k < 65537; k++) begin
            tick();
        end
        a.req1 = 1'b0;
        #1;
        chk("stats_cnt1", 32'(a.cnt1), 32'd1);
        chk("stats_cnt0", 32'(a.cnt0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hsl_arbiter.md
HSL_ARBITER -- requirements
Module: hsl_arbiter

Interface
REQ-001 SHALL have parameter: CONV_LAT, default 1, converter latency in clock edges; legal range 1..4.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  input  1  the single clock; all logic rises on posedge.
- reset  input  1  asynchronous, active-high reset.
- req0, req1  input  1  requester 0/1 presents a pixel.
- rgb0, rgb1  input  24  pixel {R[23:16], G[15:8], B[7:0]}, unsigned 8-bit per channel.
- gnt0, gnt1  output  1  combinational grant; transfer occurs on an edge where reqN and gntN are both high.
- conv_red, conv_green, conv_blue  output  8  registered drive to the shared RGB-to-HSL converter.
- conv_hue, conv_sat, conv_light  input  10  converter results.
- o_valid  output  1  result strobe, one cycle per accepted pixel.
- o_id  output  1  requester that owns the result.
- o_hue, o_sat, o_light  output  10  registered result.
- flush  input  1  stop granting and drain.
- flush_done  output  1  pipeline empty after flush.
- busy  output  1  in-flight pixels exist or FSM not in RUN.

Function
REQ-003 SHALL grant at most one requester per cycle; gnt0 and gnt1 are never both high.
REQ-004 SHALL grant only in state RUN with flush low; otherwise gnt0 = gnt1 = 0.
REQ-005 SHALL grant a lone requester immediately; on simultaneous requests it SHALL grant the requester favoured by a 1-bit round-robin pointer.
REQ-006 SHALL move the pointer to the other requester after every transfer; the pointer SHALL not change without a transfer.
REQ-007 SHALL register the granted rgb into conv_red/conv_green/conv_blue on the transfer edge E; with no transfer, conv_* SHALL hold their value.
REQ-008 SHALL track each transfer through a CONV_LAT-deep valid/id shift register and sample conv_hue/sat/light at edge E+CONV_LAT.
REQ-009 SHALL assert o_valid, o_id and o_hue/o_sat/o_light registered at edge E+CONV_LAT+1; end-to-end latency is CONV_LAT+1 edges.
REQ-010 SHALL sustain one transfer per cycle (back-to-back, alternating under contention); outputs have no backpressure.
REQ-011 SHALL hold o_hue/o_sat/o_light at their last value while o_valid is low.
REQ-012 SHALL implement FSM states and transitions:
- RUN -> DRAIN when flush is high; no grant on that edge.
- DRAIN -> DONE when the tag pipeline and output stage are empty.
- DONE -> RUN when flush is low.
REQ-013 SHALL drive flush_done high exactly while in DONE.
REQ-014 SHALL deliver every transfer accepted before flush; none are dropped.
REQ-015 SHALL compute busy = (any tag valid) OR (state != RUN).

Reset
REQ-016 SHALL, on reset high, asynchronously clear: state to RUN, pointer to requester 0, all tags to invalid, o_valid/o_id/flush_done to 0, o_hue/o_sat/o_light to 0, conv_* to 0.
REQ-017 SHALL discard in-flight pixels when reset asserts mid-operation; no o_valid SHALL appear for them after release.
REQ-018 SHALL force gnt0 = gnt1 = 0 while reset is high.

Configuration
REQ-019 SHALL, when macro HSL_ARB_STATS_EN is defined, add outputs cnt0 and cnt1 (16 bits each, reset 0): accepted-transfer counts per requester, wrapping from 65535 to 0.
REQ-020 SHALL, when HSL_ARB_STATS_EN is undefined, omit cnt0/cnt1 and their logic; all other behaviour is identical.

Verification
REQ-021 SHALL test a lone requester: req0=1, rgb0=FF0000, CONV_LAT=1 -> gnt0 same cycle, conv_red=FF after edge E, o_valid with o_id=0 after edge E+2, o_hue = converter value.
REQ-022 SHALL test contention: req0 = req1 = 1 for 6 cycles after reset -> grants 0,1,0,1,0,1; o_id sequence 0,1,0,1,0,1, contiguous o_valid.
REQ-023 SHALL test flush: flush at cycle 3 of a stream -> no grant from that cycle, all 3 accepted pixels emerge, then flush_done=1; flush low -> RUN, grants resume.
REQ-024 SHALL test reset mid-stream: reset with 2 pixels in flight -> o_valid stays 0 after release, busy=0, pointer at requester 0.
REQ-025 SHALL test CONV_LAT=4: single transfer -> o_valid exactly 5 edges after the transfer edge.
REQ-026 SHALL test statistics with HSL_ARB_STATS_EN: 65537 transfers on req1 -> cnt1=1, cnt0=0.
